cam_match_encoder: RTL and testbench
====================================

CAM_MATCH_ENCODER -- requirements
Module: cam_match_encoder

Interface
REQ-001 Parameter N_WORDS, default 4, number of match lines; legal values 2, 4, 8 only.
REQ-002 Parameter AW, default 2, address width; SHALL equal log2(N_WORDS).
REQ-003 Parameter DEPTH, default 2, result-queue depth in entries; legal values 2 or 4.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low; sampled on rising clk edge only.
REQ-006 ml_valid  input  1  match-line vector valid (search completed on the CAM array).
REQ-007 ml_ready  output  1  block can accept a match vector this cycle.
REQ-008 ml  input  N_WORDS  per-word match lines; ml[i] is the 4-input AND output of word i (1 = all bits match).
REQ-009 res_valid  output  1  result entry available at queue head.
REQ-010 res_ready  input  1  downstream consumes head result.
REQ-011 res_hit  output  1  head result: at least one word matched.
REQ-012 res_addr  output  AW  head result: index of lowest-numbered matching word; 0 on miss.
REQ-013 res_multi  output  1  head result: two or more words matched.
REQ-014 hit_cnt  output  8  saturating hit count (see Configuration).
REQ-015 miss_cnt  output  8  saturating miss count (see Configuration).

Function
REQ-016 Vector accepted SHALL mean ml_valid=1 and ml_ready=1 on the same rising edge.
REQ-017 ml_ready SHALL be 1 exactly when queue occupancy < DEPTH; no combinational path from res_ready or ml_valid to ml_ready.
REQ-018 On acceptance, encode {hit, addr, multi} from ml combinationally and push into the queue on that edge.
REQ-019 Priority: word 0 highest; addr = smallest i with ml[i]=1.
REQ-020 Latency: result of a vector accepted at edge k SHALL be at queue head with res_valid=1 after edge k when the queue was empty; otherwise in strict FIFO order.
REQ-021 Pop SHALL occur when res_valid=1 and res_ready=1; head outputs SHALL hold stable while res_valid=1 and res_ready=0.
REQ-022 Simultaneous push and pop: occupancy unchanged; when full, push not permitted that cycle (ml_ready=0) even if a pop occurs.
REQ-023 Empty queue: res_valid=0; res_hit, res_addr, res_multi SHALL read 0.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; occupancy tracked by explicit counter 0..DEPTH.
REQ-025 ml_valid=1 while ml_ready=0 SHALL NOT alter state; the vector is not captured.
REQ-026 ml=0 accepted SHALL yield hit=0, addr=0, multi=0.

Reset
REQ-027 rst_n=0 at a rising edge SHALL empty the queue, zero pointers and occupancy, and zero hit_cnt and miss_cnt.
REQ-028 After reset: res_valid=0, res_hit=0, res_addr=0, res_multi=0, ml_ready=1 from the first edge following reset release.
REQ-029 Reset mid-operation SHALL discard all queued results; a push or pop coincident with reset SHALL have no effect.

Configuration
REQ-030 Macro CAM_HIT_STATS_EN defined: hit_cnt increments on each accepted vector with hit=1 and miss_cnt on each with hit=0, both saturating at 255.
REQ-031 Macro CAM_HIT_STATS_EN undefined: no counter logic; hit_cnt and miss_cnt tied to 0; ports present in both builds.

Verification
REQ-032 Reset, then ml_valid=1, ml=4'b0100 at edge 1, res_ready=1 -> after edge 1: res_valid=1, hit=1, addr=2, multi=0; res_valid=0 after edge 2.
REQ-033 ml=4'b1010 accepted -> hit=1, addr=1, multi=1; ml=4'b0000 accepted -> hit=0, addr=0, multi=0.
REQ-034 res_ready=0, push 4'b0001 then 4'b1000 (DEPTH=2) -> ml_ready=0 after second edge; third vector 4'b0010 with ml_valid=1 is dropped; releasing res_ready yields addr 0 then 3 in order.
REQ-035 Queue full, res_ready=1 and ml_valid=1 same cycle -> one pop, no push, occupancy 1, ml_ready=1 next cycle.
REQ-036 Two entries queued, rst_n=0 for one edge -> res_valid=0, ml_ready=1, counters 0 after that edge.
REQ-037 CAM_HIT_STATS_EN defined, 300 accepted hits -> hit_cnt=255, miss_cnt=0; macro undefined -> both remain 0.

Source files
------------

// File: rtl/cam_match_encoder_if.sv
// rtl/cam_match_encoder_if.sv - match-vector and result stream bundle for cam_match_encoder
// Purpose: groups the match-vector input handshake and the result-queue output handshake.
// Signals:
//    ml_valid / ml_ready / ml                        : match-line vector stream (master -> slave)
//    res_valid / res_ready / res_hit/addr/multi      : result stream (slave -> master)
// Modports: master = CAM array / consumer side, slave = encoder.
interface cam_match_encoder_if #(
   parameter int N_WORDS = 4,
   parameter int AW      = 2
);
   logic               ml_valid;
   logic               ml_ready;
   logic [N_WORDS-1:0] ml;
   logic               res_valid;
   logic               res_ready;
   logic               res_hit;
   logic [AW-1:0]      res_addr;
   logic               res_multi;

   modport master (
      output ml_valid, ml, res_ready,
      input  ml_ready, res_valid, res_hit, res_addr, res_multi
   );

   modport slave (
      input  ml_valid, ml, res_ready,
      output ml_ready, res_valid, res_hit, res_addr, res_multi
   );
endinterface

// File: rtl/cam_match_encoder.sv
// rtl/cam_match_encoder.sv - CAM match-line priority encoder with result FIFO
// Purpose: encodes an accepted match-line vector into {hit, lowest matching addr, multi}
//          and queues it in a DEPTH-entry FIFO for a downstream consumer.
// Ports:
//    clk      : sole clock, rising edge
//    rst_n    : synchronous active-low reset
//    bus      : cam_match_encoder_if.slave (match-vector in, result out)
//    hit_cnt  : saturating count of accepted vectors with a hit
//    miss_cnt : saturating count of accepted vectors without a hit
// Option: define CAM_HIT_STATS_EN to enable hit/miss counters; otherwise they read 0.
module cam_match_encoder #(
   parameter int N_WORDS = 4,
   parameter int AW      = 2,
   parameter int DEPTH   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cam_match_encoder_if.slave   bus,
   output logic [7:0]           hit_cnt,
   output logic [7:0]           miss_cnt
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = AW + 2;

   logic [EW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [CW-1:0] r_count;

   logic          w_hit;
   logic [AW-1:0] w_addr;
   logic          w_multi;
   logic [EW-1:0] w_entry;
   logic [EW-1:0] w_head;
   logic          w_push;
   logic          w_pop;
   logic          w_nonempty;

   // Priority encode: scanning downward lets the lowest matching index win.
   always_comb begin
      w_addr = '0;
      for (int i = N_WORDS - 1; i >= 0; i--) begin
         if (bus.ml[i]) w_addr = AW'(i);
      end
   end

   assign w_hit   = |bus.ml;
   // Clearing the lowest set bit leaves something only if two or more bits were set.
   assign w_multi = |(bus.ml & (bus.ml - N_WORDS'(1)));
   assign w_entry = {w_hit, w_addr, w_multi};

   // Ready depends only on registered occupancy, never on this cycle's inputs.
   assign bus.ml_ready = (r_count < CW'(DEPTH));
   assign w_nonempty   = (r_count != '0);
   assign w_push       = bus.ml_valid & bus.ml_ready;
   assign w_pop        = w_nonempty & bus.res_ready;

   assign w_head        = r_mem[r_rd];
   assign bus.res_valid = w_nonempty;
   assign bus.res_hit   = w_nonempty & w_head[EW-1];
   assign bus.res_addr  = w_nonempty ? w_head[AW:1] : '0;
   assign bus.res_multi = w_nonempty & w_head[0];

   always_ff @(posedge clk) begin
      if (rst_n && w_push) r_mem[r_wr] <= w_entry;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
         if (w_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef CAM_HIT_STATS_EN
   logic [7:0] r_hit_cnt;
   logic [7:0] r_miss_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (w_push) begin
         if (w_hit) begin
            if (r_hit_cnt != 8'hFF) r_hit_cnt <= r_hit_cnt + 8'd1;
         end else begin
            if (r_miss_cnt != 8'hFF) r_miss_cnt <= r_miss_cnt + 8'd1;
         end
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_cam_match_encoder.sv
// tb/tb_cam_match_encoder.sv - randomized self-checking bench for cam_match_encoder
module tb_cam_match_encoder;
   localparam int N_WORDS = 4;
   localparam int AW      = 2;
   localparam int DEPTH   = 2;

   typedef struct packed {
      logic          hit;
      logic [AW-1:0] addr;
      logic          multi;
   } ent_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] hit_cnt;
   logic [7:0] miss_cnt;

   cam_match_encoder_if #(.N_WORDS(N_WORDS), .AW(AW)) bus ();

   cam_match_encoder #(.N_WORDS(N_WORDS), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_total = 0;
   int   n_bad   = 0;
   ent_t mdl_q[$];
   int   mdl_hits   = 0;
   int   mdl_misses = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference encoding straight from the rules: first set bit from word 0, popcount for multi.
   function automatic ent_t enc(input logic [N_WORDS-1:0] m);
      ent_t e;
      e       = '0;
      e.hit   = (m != '0);
      for (int i = 0; i < N_WORDS; i++) begin
         if (m[i]) begin
            e.addr = AW'(i);
            break;
         end
      end
      e.multi = ($countones(m) >= 2);
      return e;
   endfunction

   function automatic int sat(input int v);
`ifdef CAM_HIT_STATS_EN
      return (v > 255) ? 255 : v;
`else
      return 0;
`endif
   endfunction

   task automatic check_outputs(input string ph);
      ent_t h;
      h = (mdl_q.size() > 0) ? mdl_q[0] : '0;
      chk({ph, "_ml_ready"},  int'(bus.ml_ready),  int'(mdl_q.size() < DEPTH));
      chk({ph, "_res_valid"}, int'(bus.res_valid), int'(mdl_q.size() > 0));
      chk({ph, "_res_hit"},   int'(bus.res_hit),   int'(h.hit));
      chk({ph, "_res_addr"},  int'(bus.res_addr),  int'(h.addr));
      chk({ph, "_res_multi"}, int'(bus.res_multi), int'(h.multi));
      chk({ph, "_hit_cnt"},   int'(hit_cnt),       sat(mdl_hits));
      chk({ph, "_miss_cnt"},  int'(miss_cnt),      sat(mdl_misses));
   endtask

   // Drive one cycle from a negedge, advance the model over the posedge, check at the next negedge.
   task automatic step(input string ph, input logic v, input logic [N_WORDS-1:0] m,
                       input logic rr, input logic rn);
      bit   acc;
      bit   pop;
      ent_t e;
      bus.ml_valid  = v;
      bus.ml        = m;
      bus.res_ready = rr;
      rst_n         = rn;
      acc = v && (mdl_q.size() < DEPTH);
      pop = rr && (mdl_q.size() > 0);
      @(posedge clk);
      if (!rn) begin
         mdl_q.delete();
         mdl_hits   = 0;
         mdl_misses = 0;
      end else begin
         if (pop) void'(mdl_q.pop_front());
         if (acc) begin
            e = enc(m);
            mdl_q.push_back(e);
            if (e.hit) mdl_hits++;
            else       mdl_misses++;
         end
      end
      @(negedge clk);
      check_outputs(ph);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.ml_valid  = 1'b0;
      bus.ml        = '0;
      bus.res_ready = 1'b0;
      @(negedge clk);
      step("rst", 0, 4'b0000, 0, 0);
      step("rst2", 0, 4'b0000, 0, 0);
      step("idle", 0, 4'b0000, 0, 1);

      // Single-hit latency and pop on the following edge.
      step("r32a", 1, 4'b0100, 1, 1);
      chk("r32_addr", int'(bus.res_addr), 2);
      step("r32b", 0, 4'b0000, 1, 1);
      chk("r32_empty", int'(bus.res_valid), 0);

      // Multi-match and all-miss encodings.
      step("r33a", 1, 4'b1010, 0, 1);
      chk("r33_multi", int'(bus.res_multi), 1);
      step("r33b", 1, 4'b0000, 1, 1);
      step("r33c", 0, 4'b0000, 1, 1);
      chk("r33_miss_hit", int'(bus.res_hit), 0);
      step("r33d", 0, 4'b0000, 1, 1);

      // Fill, drop on full, drain in order.
      step("r34a", 1, 4'b0001, 0, 1);
      step("r34b", 1, 4'b1000, 0, 1);
      chk("r34_full", int'(bus.ml_ready), 0);
      step("r34c", 1, 4'b0010, 0, 1);
      chk("r34_head0", int'(bus.res_addr), 0);
      step("r34d", 0, 4'b0000, 1, 1);
      chk("r34_head1", int'(bus.res_addr), 3);
      step("r34e", 0, 4'b0000, 1, 1);
      chk("r34_drained", int'(bus.res_valid), 0);

      // Full with simultaneous pop and offered push: pop only.
      step("r35a", 1, 4'b0011, 0, 1);
      step("r35b", 1, 4'b0110, 0, 1);
      step("r35c", 1, 4'b1111, 1, 1);
      chk("r35_ready", int'(bus.ml_ready), 1);
      step("r35d", 0, 4'b0000, 1, 1);
      step("r35e", 0, 4'b0000, 1, 1);

      // Reset with two entries queued, push offered coincident with reset.
      step("r36a", 1, 4'b0101, 0, 1);
      step("r36b", 1, 4'b1100, 0, 1);
      step("r36c", 1, 4'b0001, 1, 0);
      chk("r36_valid", int'(bus.res_valid), 0);
      chk("r36_ready", int'(bus.ml_ready), 1);
      step("r36d", 0, 4'b0000, 0, 1);

      // Randomized traffic, occasional reset.
      for (int i = 0; i < 1500; i++) begin
         logic [N_WORDS-1:0] m;
         m = ($urandom_range(0, 3) == 0) ? '0 : N_WORDS'($urandom);
         step("rnd", 1'($urandom_range(0, 1)), m, ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 199) != 0));
      end

      // Counter saturation with hits only.
      step("satrst", 0, 4'b0000, 0, 0);
      for (int i = 0; i < 300; i++) begin
         step("sat", 1, N_WORDS'($urandom_range(1, 15)), 1, 1);
      end
`ifdef CAM_HIT_STATS_EN
      chk("r37_hit_cnt", int'(hit_cnt), 255);
`else
      chk("r37_hit_cnt", int'(hit_cnt), 0);
`endif
      chk("r37_miss_cnt", int'(miss_cnt), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
